// File: rtl/edge_history.sv
// Edge history for the PWL step-response taps: keeps the newest N_TAPS edges and
// reports per-tap elapsed time. Optional statistics ports under EDGE_HISTORY_STATS_EN.
module edge_history #(
    parameter int N_TAPS     = 8,
    parameter int TIME_WIDTH = 32,
    parameter int IN_WIDTH   = 16,
    parameter int MAX_DT     = 65535,
    parameter int CNT_WIDTH  = $clog2(N_TAPS + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [TIME_WIDTH-1:0]        time_now,
    input  logic                         edge_valid,
    input  logic [TIME_WIDTH-1:0]        edge_time,
    input  logic                         edge_sign,
    output logic [N_TAPS*IN_WIDTH-1:0]   tap_dt,
    output logic [N_TAPS-1:0]            tap_sign,
    output logic [N_TAPS-1:0]            tap_valid,
    output logic [CNT_WIDTH-1:0]         count
`ifdef EDGE_HISTORY_STATS_EN
    ,
    output logic [15:0]                  drop_cnt,
    output logic                         late_flag
`endif
);

    localparam logic [TIME_WIDTH-1:0] MAX_DT_T = TIME_WIDTH'(MAX_DT);
    localparam logic [IN_WIDTH-1:0]   MAX_DT_O = IN_WIDTH'(MAX_DT);

    // Wrapped difference -> PWL input: future edges read 0, settled edges saturate.
    function automatic logic [IN_WIDTH-1:0] clamp_dt(input logic [TIME_WIDTH-1:0] diff);
        logic [IN_WIDTH-1:0] dt;
        if (diff[TIME_WIDTH-1]) begin
            dt = '0;
        end else if (diff >= MAX_DT_T) begin
            dt = MAX_DT_O;
        end else begin
            dt = diff[IN_WIDTH-1:0];
        end
        return dt;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] popcount(input logic [N_TAPS-1:0] v);
        logic [CNT_WIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < N_TAPS; i++) begin
            c = c + CNT_WIDTH'(v[i]);
        end
        return c;
    endfunction

    logic [TIME_WIDTH-1:0]              ent_time_r [N_TAPS];
    logic [N_TAPS-1:0]                  ent_sign_r;
    logic [N_TAPS-1:0]                  ent_valid_r;

    logic [N_TAPS-1:0][IN_WIDTH-1:0]    tap_dt_r;
    logic [N_TAPS-1:0]                  tap_sign_r;
    logic [N_TAPS-1:0]                  tap_valid_r;
    logic [CNT_WIDTH-1:0]               count_r;

    logic [TIME_WIDTH-1:0]              diff_s     [N_TAPS];
    logic [N_TAPS-1:0][IN_WIDTH-1:0]    dt_pre_s;
    logic [N_TAPS-1:0]                  future_s;
    logic [N_TAPS-1:0]                  live_s;
    logic [TIME_WIDTH-1:0]              new_diff_s;
    logic [TIME_WIDTH-1:0]              nxt_time_s [N_TAPS];
    logic [N_TAPS-1:0]                  nxt_sign_s;
    logic [N_TAPS-1:0]                  nxt_valid_s;
    logic [N_TAPS-1:0][IN_WIDTH-1:0]    nxt_dt_s;

    // Expiry on the pre-shift contents, then optional shift with the new edge in slot 0.
    always_comb begin
        new_diff_s = time_now - edge_time;
        for (int k = 0; k < N_TAPS; k++) begin
            diff_s[k]   = time_now - ent_time_r[k];
            future_s[k] = diff_s[k][TIME_WIDTH-1];
            live_s[k]   = ent_valid_r[k] && !(!future_s[k] && (diff_s[k] >= MAX_DT_T));
            dt_pre_s[k] = clamp_dt(diff_s[k]);
        end
        if (edge_valid) begin
            nxt_time_s[0]  = edge_time;
            nxt_sign_s[0]  = edge_sign;
            nxt_valid_s[0] = 1'b1;
            nxt_dt_s[0]    = clamp_dt(new_diff_s);
            for (int k = 1; k < N_TAPS; k++) begin
                nxt_time_s[k]  = ent_time_r[k-1];
                nxt_sign_s[k]  = ent_sign_r[k-1];
                nxt_valid_s[k] = live_s[k-1];
                nxt_dt_s[k]    = dt_pre_s[k-1];
            end
        end else begin
            for (int k = 0; k < N_TAPS; k++) begin
                nxt_time_s[k]  = ent_time_r[k];
                nxt_sign_s[k]  = ent_sign_r[k];
                nxt_valid_s[k] = live_s[k];
                nxt_dt_s[k]    = dt_pre_s[k];
            end
        end
    end

    // Entry storage and registered tap outputs; dead taps show a settled step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_TAPS; k++) begin
                ent_time_r[k] <= '0;
            end
            ent_sign_r  <= '0;
            ent_valid_r <= '0;
            tap_dt_r    <= '0;
            tap_sign_r  <= '0;
            tap_valid_r <= '0;
            count_r     <= '0;
        end else begin
            for (int k = 0; k < N_TAPS; k++) begin
                ent_time_r[k] <= nxt_time_s[k];
                tap_dt_r[k]   <= nxt_valid_s[k] ? nxt_dt_s[k] : MAX_DT_O;
            end
            ent_sign_r  <= nxt_sign_s;
            ent_valid_r <= nxt_valid_s;
            tap_sign_r  <= nxt_sign_s & nxt_valid_s;
            tap_valid_r <= nxt_valid_s;
            count_r     <= popcount(nxt_valid_s);
        end
    end

    assign tap_dt    = tap_dt_r;
    assign tap_sign  = tap_sign_r;
    assign tap_valid = tap_valid_r;
    assign count     = count_r;

`ifdef EDGE_HISTORY_STATS_EN
    logic [15:0] drop_cnt_r;
    logic        late_flag_r;
    logic        drop_s;
    logic        late_set_s;

    assign drop_s     = edge_valid && live_s[N_TAPS-1];
    assign late_set_s = (|(ent_valid_r & future_s)) || (edge_valid && new_diff_s[TIME_WIDTH-1]);

    // Saturating drop counter and sticky late-timestamp flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_r  <= 16'h0000;
            late_flag_r <= 1'b0;
        end else begin
            if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
                drop_cnt_r <= drop_cnt_r + 16'h0001;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
            late_flag_r <= late_flag_r | late_set_s;
        end
    end

    assign drop_cnt  = drop_cnt_r;
    assign late_flag = late_flag_r;
`endif

endmodule

// File: tb/tb_edge_history.sv
// Scoreboard bench for edge_history (MAX_DT = 100); stats checks follow EDGE_HISTORY_STATS_EN.
module tb_edge_history;

    localparam int N   = 8;
    localparam int TW  = 32;
    localparam int IW  = 16;
    localparam int MDT = 100;
    localparam int CW  = $clog2(N + 1);

    localparam int K_DT    = 0;
    localparam int K_VALID = 1;
    localparam int K_SIGN  = 2;
    localparam int K_COUNT = 3;
    localparam int K_DROP  = 4;
    localparam int K_LATE  = 5;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [TW-1:0]       time_now = '0;
    logic                edge_valid = 1'b0;
    logic [TW-1:0]       edge_time = '0;
    logic                edge_sign = 1'b0;
    logic [N*IW-1:0]     tap_dt;
    logic [N-1:0]        tap_sign;
    logic [N-1:0]        tap_valid;
    logic [CW-1:0]       count;
`ifdef EDGE_HISTORY_STATS_EN
    logic [15:0]         drop_cnt;
    logic                late_flag;
`endif

    edge_history #(.N_TAPS(N), .TIME_WIDTH(TW), .IN_WIDTH(IW), .MAX_DT(MDT)) dut (
        .clk(clk), .rst_n(rst_n), .time_now(time_now), .edge_valid(edge_valid),
        .edge_time(edge_time), .edge_sign(edge_sign), .tap_dt(tap_dt),
        .tap_sign(tap_sign), .tap_valid(tap_valid), .count(count)
`ifdef EDGE_HISTORY_STATS_EN
        , .drop_cnt(drop_cnt), .late_flag(late_flag)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          stamp;
        int          kind;
        int          idx;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   cmp_cnt = 0;
    int   err_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] get_actual(input int kind, input int idx);
        logic [31:0] a;
        case (kind)
            K_DT:    a = 32'(tap_dt[idx*IW +: IW]);
            K_VALID: a = 32'(tap_valid);
            K_SIGN:  a = 32'(tap_sign);
            K_COUNT: a = 32'(count);
`ifdef EDGE_HISTORY_STATS_EN
            K_DROP:  a = 32'(drop_cnt);
            K_LATE:  a = 32'(late_flag);
`endif
            default: a = 32'hDEAD_BEEF;
        endcase
        return a;
    endfunction

    // Expected response for the outputs that follow the inputs being driven now.
    task automatic push_exp(input string name, input int kind, input int idx, input logic [31:0] val);
        exp_t e;
        e.stamp = cyc + 1;
        e.kind  = kind;
        e.idx   = idx;
        e.val   = val;
        e.name  = name;
        sb.push_back(e);
    endtask

    // Monitor: compare every expectation due at this cycle, away from the active edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].stamp <= cyc) begin
            e = sb.pop_front();
            if (e.stamp != cyc) begin
                check({e.name, "_stale"}, 32'(e.stamp), 32'(cyc));
            end else begin
                check(e.name, get_actual(e.kind, e.idx), e.val);
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        edge_valid = 1'b0;
        cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic push(input logic [TW-1:0] tn, input logic [TW-1:0] et, input logic sg);
        time_now   = tn;
        edge_valid = 1'b1;
        edge_time  = et;
        edge_sign  = sg;
    endtask

    initial begin
        int t;
        repeat (3) cycle();
        check("reset_valid", 32'(tap_valid), 32'h0);
        check("reset_count", 32'(count), 32'h0);
        check("reset_dt0", 32'(tap_dt[IW-1:0]), 32'h0);
        rst_n = 1'b1;

        // Idle ramp: nothing live, every tap shows a settled step.
        for (int i = 0; i <= 100; i++) begin
            time_now = TW'(i);
            if (i == 100) begin
                for (int k = 0; k < N; k++) push_exp($sformatf("idle_dt%0d", k), K_DT, k, 32'd100);
                push_exp("idle_valid", K_VALID, 0, 32'h0);
                push_exp("idle_sign", K_SIGN, 0, 32'h0);
                push_exp("idle_count", K_COUNT, 0, 32'h0);
            end
            cycle();
        end

        // Single edge then ageing.
        do_reset();
        push(32'd10, 32'd10, 1'b1);
        push_exp("single_valid", K_VALID, 0, 32'h01);
        push_exp("single_dt0", K_DT, 0, 32'd0);
        push_exp("single_sign", K_SIGN, 0, 32'h01);
        push_exp("single_count", K_COUNT, 0, 32'd1);
        cycle();
        edge_valid = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            time_now = TW'(10 + i);
            if (i == 25) push_exp("single_dt0_age", K_DT, 0, 32'd25);
            cycle();
        end

        // Ordering and overflow: nine pushes into eight slots.
        do_reset();
        for (int i = 0; i <= 8; i++) begin
            t = 10 * i;
            push(TW'(t), TW'(t), i[0]);
            if (i == 8) begin
                push_exp("ord_dt0", K_DT, 0, 32'd0);
                push_exp("ord_dt3", K_DT, 3, 32'd30);
                push_exp("ord_dt7", K_DT, 7, 32'd70);
                push_exp("ord_valid", K_VALID, 0, 32'hFF);
                push_exp("ord_sign", K_SIGN, 0, 32'hAA);
                push_exp("ord_count", K_COUNT, 0, 32'd8);
`ifdef EDGE_HISTORY_STATS_EN
                push_exp("ord_drop", K_DROP, 0, 32'd1);
`endif
            end
            cycle();
        end

        // Expiry boundary at MAX_DT.
        do_reset();
        push(32'd0, 32'd0, 1'b0);
        cycle();
        edge_valid = 1'b0;
        time_now = 32'd99;
        push_exp("exp99_valid", K_VALID, 0, 32'h01);
        push_exp("exp99_dt0", K_DT, 0, 32'd99);
        push_exp("exp99_count", K_COUNT, 0, 32'd1);
        cycle();
        time_now = 32'd100;
        push_exp("exp100_valid", K_VALID, 0, 32'h00);
        push_exp("exp100_dt0", K_DT, 0, 32'd100);
        push_exp("exp100_count", K_COUNT, 0, 32'd0);
        cycle();

        // Expiry and push together: the expired entry shifts in dead.
        do_reset();
        push(32'd0, 32'd0, 1'b1);
        cycle();
        push(32'd100, 32'd100, 1'b0);
        push_exp("expush_valid", K_VALID, 0, 32'h01);
        push_exp("expush_dt0", K_DT, 0, 32'd0);
        push_exp("expush_dt1", K_DT, 1, 32'd100);
        push_exp("expush_sign", K_SIGN, 0, 32'h00);
        push_exp("expush_count", K_COUNT, 0, 32'd1);
        cycle();

        // Timestamp wrap.
        do_reset();
        push(32'h0000_0010, 32'hFFFF_FFF0, 1'b0);
        push_exp("wrap_dt0", K_DT, 0, 32'd32);
        push_exp("wrap_valid", K_VALID, 0, 32'h01);
        cycle();

        // Future edge.
        do_reset();
        push(32'd40, 32'd50, 1'b1);
        push_exp("future_dt0", K_DT, 0, 32'd0);
        push_exp("future_valid", K_VALID, 0, 32'h01);
`ifdef EDGE_HISTORY_STATS_EN
        push_exp("future_late", K_LATE, 0, 32'd1);
`endif
        cycle();
        edge_valid = 1'b0;
        time_now = 32'd60;
        push_exp("future_dt0_later", K_DT, 0, 32'd10);
        cycle();

        // Async reset pulse between clock edges with five live taps.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push(TW'(i), TW'(i), 1'b1);
            if (i == 4) push_exp("async_pre_count", K_COUNT, 0, 32'd5);
            cycle();
        end
        edge_valid = 1'b0;
        cycle();
        #3;
        rst_n = 1'b0;
        #1;
        check("async_valid", 32'(tap_valid), 32'h0);
        check("async_count", 32'(count), 32'h0);
        check("async_sign", 32'(tap_sign), 32'h0);
        check("async_dt4", 32'(tap_dt[4*IW +: IW]), 32'h0);
        rst_n = 1'b1;
        cycle();
        push(32'd7, 32'd7, 1'b0);
        push_exp("after_reset_valid", K_VALID, 0, 32'h01);
        push_exp("after_reset_count", K_COUNT, 0, 32'd1);
        cycle();
        edge_valid = 1'b0;

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 5 && sb.size() > 0; i++) cycle();
        if (sb.size() != 0) begin
            err_cnt++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
